vga_fb_arbiter: RTL and testbench

- Sole owner of the single-port frame-buffer RAM. Shares it between the VGA scan-out, the drawing engine and a built-in clear-screen engine.
- Scan-out reads are never delayed. Draw writes are buffered in a FIFO and retired only in cycles the scan-out does not need the RAM. Clears run in the same free cycles.
- Sits between the vga timing block (next_x/next_y) and the RAM. Its pixel outputs feed R_in/G_in/B_in.

---
 rtl/vga_fb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: sole owner of the single-port frame-buffer RAM.
//   Scan-out reads always win the RAM slot. Draw writes queue in a FIFO and retire in
//   free slots. A built-in clear engine fills the screen with one colour in free slots.
//   While a clear runs, FIFO pops are held off so queued writes land on top of it.
// Ports:
//   CLOCK_25, reset               pixel clock, async active-high reset
//   fetch_en, next_x, next_y      scan-out read request
//   wr_valid/wr_ready, wr_x/y/data draw write handshake (out-of-screen writes dropped)
//   clr_start, clr_color          start a full-screen clear
//   clr_busy, clr_done            clear status / completion pulse
//   mem_addr/we/wdata, mem_rdata  RAM interface (registered outputs, 1-cycle read)
//   R_out/G_out/B_out, pix_valid  fetched pixel, three cycles after fetch_en
// Optional: define VGA_FB_ARBITER_OVF_CNT_EN to add ovf_count[15:0], a saturating
//   count of cycles with wr_valid high while wr_ready is low.
module vga_fb_arbiter #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        R_out,
  output logic [7:0]        G_out,
  output logic [7:0]        B_out,
  output logic              pix_valid
`ifdef VGA_FB_ARBITER_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [CntW-1:0]   FullCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // Linear address y*WIDTH+x; shift-add form for the default 640-wide screen.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] x32, y32, a;
    x32 = {22'd0, x};
    y32 = {22'd0, y};
    if (WIDTH == 32'd640) a = (y32 << 9) + (y32 << 7) + x32;
    else                  a = y32 * WIDTH + x32;
    return a[ADDR_W-1:0];
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] clr_color_q;
  logic [EntW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              fetch_q1, fetch_q2;

  logic              in_bounds, push, store, pop, fifo_empty;
  logic [EntW-1:0]   head;

  assign wr_ready = (count_q != FullCnt);

  always_comb begin
    in_bounds  = ({22'd0, wr_x} < WIDTH) && ({22'd0, wr_y} < HEIGHT);
    push       = wr_valid && wr_ready;
    // Off-screen writes complete the handshake but never occupy an entry.
    store      = push && in_bounds;
    fifo_empty = (count_q == '0);
    pop        = !fetch_en && (state_q == StIdle) && !fifo_empty;
    head       = fifo_mem[rd_ptr_q];
  end

  always_ff @(posedge CLOCK_25) begin
    if (store) fifo_mem[wr_ptr_q] <= {pix_addr(wr_x, wr_y), wr_data};
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      fetch_q1    <= 1'b0;
      fetch_q2    <= 1'b0;
      R_out       <= '0;
      G_out       <= '0;
      B_out       <= '0;
      pix_valid   <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      mem_we   <= 1'b0;

      // RAM slot: scan-out read, then clear, then FIFO head; otherwise hold the address.
      if (fetch_en) begin
        mem_addr <= pix_addr(next_x, next_y);
      end else if (state_q == StClear) begin
        mem_addr  <= clr_cnt_q;
        mem_wdata <= clr_color_q;
        mem_we    <= 1'b1;
        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LastAddr) begin
          state_q  <= StIdle;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end
      end else if (pop) begin
        mem_addr  <= head[EntW-1:DATA_W];
        mem_wdata <= head[DATA_W-1:0];
        mem_we    <= 1'b1;
      end

      if ((state_q == StIdle) && clr_start) begin
        state_q     <= StClear;
        clr_cnt_q   <= '0;
        clr_color_q <= clr_color;
        clr_busy    <= 1'b1;
      end

      if (store) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({store, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase

      // Address goes out one edge after fetch_en, data returns one edge later.
      fetch_q1  <= fetch_en;
      fetch_q2  <= fetch_q1;
      pix_valid <= fetch_q2;
      if (fetch_q2) begin
        R_out <= mem_rdata[23:16];
        G_out <= mem_rdata[15:8];
        B_out <= mem_rdata[7:0];
      end
    end
  end

`ifdef VGA_FB_ARBITER_OVF_CNT_EN
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (wr_valid && !wr_ready && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_vga_fb_arbiter;
  localparam int unsigned W     = 640;
  localparam int unsigned H     = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NPIX  = W * H;
  localparam int unsigned MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_en = 1'b0;
  logic [9:0]    next_x = '0, next_y = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [9:0]    wr_x = '0, wr_y = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy, clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [7:0]    R_out, G_out, B_out;
  logic          pix_valid;
`ifdef VGA_FB_ARBITER_OVF_CNT_EN
  logic [15:0]   ovf_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .CLOCK_25(clk), .reset(reset), .fetch_en(fetch_en), .next_x(next_x), .next_y(next_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .R_out(R_out), .G_out(G_out), .B_out(B_out), .pix_valid(pix_valid)
`ifdef VGA_FB_ARBITER_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  // Synchronous single-port RAM, read-first.
  logic [DW-1:0] ram [0:MSIZE-1];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] mmem [0:MSIZE-1];
  bit            m_clearing;
  int unsigned   m_cnt;
  logic [DW-1:0] m_color;
  bit            pend_we;
  int unsigned   pend_addr;
  logic [DW-1:0] pend_data;
  bit            f1_v, f2_v;
  logic [DW-1:0] f1_d, f2_d;
  bit            e_we, e_ready, e_busy, e_done, e_pv, live;
  int unsigned   e_addr, e_ovf;
  logic [DW-1:0] e_wdata, e_rgb;

  function automatic int unsigned addr_of(input int unsigned x, input int unsigned y);
    return (y * W + x) % MSIZE;
  endfunction

  initial begin
    for (int i = 0; i < int'(MSIZE); i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_clearing = 0; m_cnt = 0; m_color = '0;
      pend_we = 0; f1_v = 0; f2_v = 0; f1_d = '0; f2_d = '0;
      e_we = 0; e_addr = 0; e_wdata = '0; e_ready = 1; e_busy = 0; e_done = 0;
      e_pv = 0; e_rgb = '0; e_ovf = 0; live = 0;
    end else begin
      bit  rdy, was_clear;
      wr_t w;
      rdy       = q.size() < DEPTH;
      was_clear = m_clearing;
      // The write issued last cycle reaches the RAM on this edge.
      if (pend_we) mmem[pend_addr] = pend_data;
      pend_we = 0;
      e_pv = f2_v;
      if (f2_v) e_rgb = f2_d;
      f2_v = f1_v; f2_d = f1_d; f1_v = 0;
      e_we = 0; e_done = 0;
      if (fetch_en) begin
        e_addr = addr_of(next_x, next_y);
        f1_v = 1; f1_d = mmem[e_addr];
      end else if (m_clearing) begin
        e_we = 1; e_addr = m_cnt; e_wdata = m_color;
        m_cnt++;
        if (m_cnt == NPIX) begin m_clearing = 0; e_done = 1; end
      end else if (q.size() > 0) begin
        w = q.pop_front();
        e_we = 1; e_addr = w.addr; e_wdata = w.data;
      end
      if (e_we) begin pend_we = 1; pend_addr = e_addr; pend_data = e_wdata; end
      if (!was_clear && clr_start) begin m_clearing = 1; m_cnt = 0; m_color = clr_color; end
      if (wr_valid && rdy && wr_x < W && wr_y < H) begin
        w.addr = addr_of(wr_x, wr_y); w.data = wr_data;
        q.push_back(w);
      end
      if (wr_valid && !rdy && e_ovf < 65535) e_ovf++;
      e_ready = q.size() < DEPTH;
      e_busy  = m_clearing;
      live    = 1;
    end
  end

  always @(negedge clk) begin
    if (!reset && live) begin
      chk("wr_ready", 32'(wr_ready), 32'(e_ready));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), e_addr);
      if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("clr_busy", 32'(clr_busy), 32'(e_busy));
      chk("clr_done", 32'(clr_done), 32'(e_done));
      chk("pix_valid", 32'(pix_valid), 32'(e_pv));
      chk("rgb", 32'({R_out, G_out, B_out}), 32'(e_rgb));
`ifdef VGA_FB_ARBITER_OVF_CNT_EN
      chk("ovf_count", 32'(ovf_count), e_ovf);
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_clr_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_rgb"}, 32'({R_out, G_out, B_out}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, nclr, bad, writes;
    logic [DW-1:0] d;

    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // Scan latency: write 0x123456 at (1,1), then fetch it.
    wr_valid = 1; wr_x = 10'd1; wr_y = 10'd1; wr_data = 24'h123456;
    tick();
    wr_valid = 0;
    repeat (3) tick();
    fetch_en = 1; next_x = 10'd1; next_y = 10'd1;
    tick();
    chk("scan_addr", 32'(mem_addr), 32'd641);
    chk("scan_we", 32'(mem_we), 32'd0);
    fetch_en = 0;
    tick();
    tick();
    chk("scan_pix_valid", 32'(pix_valid), 32'd1);
    chk("scan_R", 32'(R_out), 32'h12);
    chk("scan_G", 32'(G_out), 32'h34);
    chk("scan_B", 32'(B_out), 32'h56);

    // Priority: fetch_en starves a queued write.
    fetch_en = 1; next_x = 10'd3; next_y = 10'd2;
    wr_valid = 1; wr_x = 10'd5; wr_y = 10'd0; wr_data = 24'hABCDEF;
    tick();
    wr_valid = 0;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_we) writes++;
    end
    chk("prio_no_write", 32'(writes), 32'd0);
    fetch_en = 0;
    tick();
    chk("prio_we", 32'(mem_we), 32'd1);
    chk("prio_addr", 32'(mem_addr), 32'd5);
    chk("prio_wdata", 32'(mem_wdata), 32'hABCDEF);

    // Full FIFO, then drain in push order.
    fetch_en = 1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1; wr_x = 10'(10 + i); wr_y = 10'd2; wr_data = {8'(i), 16'hC0DE};
      tick();
    end
    wr_valid = 0;
    chk("full_not_ready", 32'(wr_ready), 32'd0);
    fetch_en = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      d = {8'(i), 16'hC0DE};
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'(1280 + 10 + i));
      chk("drain_wdata", 32'(mem_wdata), 32'(d));
      if (i == 0) chk("ready_after_pop", 32'(wr_ready), 32'd1);
    end

    // Off-screen writes are accepted and dropped.
    wr_valid = 1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 24'h111111;
    tick();
    chk("oob_x_ready", 32'(wr_ready), 32'd1);
    wr_x = 10'd0; wr_y = 10'd4;
    tick();
    wr_valid = 0;
    chk("oob_y_ready", 32'(wr_ready), 32'd1);
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we) writes++;
    end
    chk("oob_no_write", 32'(writes), 32'd0);

    // Full-screen clear with a queued write and an ignored restart.
    clr_color = 24'h0000FF; clr_start = 1;
    tick();
    clr_start = 0; clr_color = '0;
    chk("clr_busy_rise", 32'(clr_busy), 32'd1);
    n = 0; nclr = 0; bad = 0;
    while (clr_busy && n < int'(NPIX) + 50) begin
      n++;
      wr_valid = (n == 100); wr_x = 10'd7; wr_y = 10'd3; wr_data = 24'h777777;
      clr_start = (n == 200); clr_color = (n == 200) ? 24'hFF0000 : 24'h0;
      tick();
      if (mem_we && mem_wdata == 24'h0000FF) nclr++;
      if (mem_we && mem_wdata != 24'h0000FF) bad++;
    end
    wr_valid = 0; clr_start = 0;
    chk("clr_busy_cycles", 32'(n), NPIX);
    chk("clr_writes", 32'(nclr), NPIX);
    chk("clr_other_writes", 32'(bad), 32'd0);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_last_addr", 32'(mem_addr), NPIX - 1);
    tick();
    chk("clr_done_low", 32'(clr_done), 32'd0);
    chk("post_clr_we", 32'(mem_we), 32'd1);
    chk("post_clr_addr", 32'(mem_addr), 32'd1927);
    chk("post_clr_wdata", 32'(mem_wdata), 32'h777777);
    tick();

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 8000; c++) begin
      fetch_en  = ($urandom_range(0, 99) < 45);
      next_x    = 10'($urandom_range(0, W - 1));
      next_y    = 10'($urandom_range(0, H - 1));
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_x      = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(W, 1023))
                                               : 10'($urandom_range(0, W - 1));
      wr_y      = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(H, 1023))
                                               : 10'($urandom_range(0, H - 1));
      wr_data   = 24'($urandom);
      clr_start = ($urandom_range(0, 2999) == 0) || (c == 100);
      clr_color = 24'($urandom);
      if (c == 4000) begin
        reset = 1;
        tick();
        tick();
        check_reset_state("midreset");
        reset = 0;
        check_reset_state("release");
      end
      tick();
    end
    fetch_en = 0; wr_valid = 0; clr_start = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
